// File: rtl/dcpu_pkg.sv
// Shared definitions for the dcpu memory bus: arbiter state encoding,
// default watchdog length and the read data returned on a forced termination.
package dcpu_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int          ARB_TIMEOUT_DEFAULT = 64;
   localparam logic [15:0] BUS_ERR_DATA        = 16'h0000;

endpackage

// File: rtl/rr_pick2.sv
// Two-way winner select for the bus arbiter. Purely combinational so an
// uncontended request is granted in the same cycle it is raised.
module rr_pick2 #(
   parameter bit PRIO_M0 = 1'b0
) (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic pick,
   output logic any
);

   // Lone requester wins; on contention either master 0 (fixed priority)
   // or the master not served last time (round-robin).
   always_comb begin
      any = req0 | req1;
      if (req0 && req1) begin
         pick = PRIO_M0 ? 1'b0 : ~last;
      end else begin
         pick = req1;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the shared dcpu memory bus.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no grant held; winner picked combinationally from live requests
//   BUSY  | r_owner holds the bus until ack, cs drop or watchdog expiry
//
// Grant and slave-side muxing are combinational so an uncontended master
// sees no added latency. The watchdog counts the first cs cycle (in IDLE)
// as 1, so a transaction that never acks occupies exactly TIMEOUT cycles.
module bus_arbiter
   import dcpu_pkg::*;
#(
   parameter bit PRIO_M0 = 1'b0,
   parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT,
   parameter int TO_W    = 7
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_m0_cs,
   input  logic        i_m1_cs,
   input  logic        i_m0_we,
   input  logic        i_m1_we,
   input  logic [15:0] i_m0_addr,
   input  logic [15:0] i_m1_addr,
   input  logic [15:0] i_m0_dat,
   input  logic [15:0] i_m1_dat,
   output logic [15:0] o_m0_dat,
   output logic [15:0] o_m1_dat,
   output logic        o_m0_ack,
   output logic        o_m1_ack,
   output logic        o_s_cs,
   output logic        o_s_we,
   output logic [15:0] o_s_addr,
   output logic [15:0] o_s_dat,
   input  logic [15:0] i_s_dat,
   input  logic        i_s_ack,
   output logic        o_timeout,
   output logic        o_timeout_owner
);

   localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0] CNT_ONE  = TO_W'(1);

   arb_state_t      r_state;
   logic            r_owner;
   logic            r_last;
   logic            r_to_owner;
   logic [TO_W-1:0] r_cnt;

   logic            pick;
   logic            any_req;
   logic            winner;
   logic            win_cs;
   logic            win_we;
   logic [15:0]     win_addr;
   logic [15:0]     win_dat;
   logic            timeout_hit;

   rr_pick2 #(
      .PRIO_M0 (PRIO_M0)
   ) u_pick (
      .req0 (i_m0_cs),
      .req1 (i_m1_cs),
      .last (r_last),
      .pick (pick),
      .any  (any_req)
   );

   // Current winner and its request lines; in BUSY the owner is locked in.
   always_comb begin
      winner      = (r_state == BUSY) ? r_owner : pick;
      win_cs      = winner ? i_m1_cs   : i_m0_cs;
      win_we      = winner ? i_m1_we   : i_m0_we;
      win_addr    = winner ? i_m1_addr : i_m0_addr;
      win_dat     = winner ? i_m1_dat  : i_m0_dat;
      // The expiry cycle takes precedence over a late ack: cs is already low.
      timeout_hit = (r_state == BUSY) && win_cs && (r_cnt == CNT_LAST);
   end

   // Slave drive and per-master responses; everything is quiet during reset.
   always_comb begin
      o_s_cs          = ~i_reset & win_cs & ~timeout_hit;
      o_s_we          = o_s_cs & win_we;
      o_s_addr        = win_addr;
      o_s_dat         = win_dat;
      o_m0_ack        = ~i_reset & ~winner & i_m0_cs & (timeout_hit | i_s_ack);
      o_m1_ack        = ~i_reset &  winner & i_m1_cs & (timeout_hit | i_s_ack);
      o_m0_dat        = (timeout_hit && !winner) ? BUS_ERR_DATA : i_s_dat;
      o_m1_dat        = (timeout_hit &&  winner) ? BUS_ERR_DATA : i_s_dat;
      o_timeout       = ~i_reset & timeout_hit;
      // Reflect the expiring owner immediately, then hold it.
      o_timeout_owner = timeout_hit ? winner : r_to_owner;
   end

   // Grant FSM with watchdog counter and round-robin history.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_owner    <= 1'b0;
         r_last     <= 1'b1;
         r_cnt      <= '0;
         r_to_owner <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (any_req) begin
                  if (i_s_ack) begin
                     r_last <= pick;
                  end else begin
                     r_state <= BUSY;
                     r_owner <= pick;
                     r_cnt   <= CNT_ONE;
                  end
               end
            end
            BUSY: begin
               if (!win_cs) begin
                  // Owner abandoned the request: release without touching history.
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (timeout_hit) begin
                  r_state    <= IDLE;
                  r_last     <= r_owner;
                  r_to_owner <= r_owner;
                  r_cnt      <= '0;
               end else if (i_s_ack) begin
                  r_state <= IDLE;
                  r_last  <= r_owner;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
